// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types and default sizes for the multi-context register file
package rf_pkg;

   // Controller states: normal operation, or zeroing a target bank before a switch
   typedef enum logic {
      RF_IDLE  = 1'b0,
      RF_CLEAR = 1'b1
   } rf_state_t;

   localparam int RF_XLEN  = 32;
   localparam int RF_NREGS = 32;
   localparam int RF_NCTX  = 4;

endpackage

// File: rtl/rf_ctx_ctrl.sv
// rtl/rf_ctx_ctrl.sv - context-switch controller: active bank, ack pulse, background clear sequencer
import rf_pkg::*;

module rf_ctx_ctrl #(
   parameter int NREGS = RF_NREGS,
   parameter int NCTX  = RF_NCTX
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     CTX_SWITCH_REQ,
   input  logic [$clog2(NCTX)-1:0]  CTX_ID,
   input  logic                     CTX_CLEAR,
   output logic                     CTX_SWITCH_ACK,
   output logic                     CTX_BUSY,
   output logic [$clog2(NCTX)-1:0]  CTX_ACTIVE,
   output logic                     clear_en,
   output logic [$clog2(NCTX)-1:0]  clear_bank,
   output logic [$clog2(NREGS)-1:0] clear_index
);

   localparam int AW = $clog2(NREGS);
   localparam int CW = $clog2(NCTX);

   rf_state_t state_q, state_d;
   logic [AW-1:0] count_q, count_d;
   logic [CW-1:0] target_q, target_d;
   logic [CW-1:0] active_q, active_d;
   logic          ack_q, ack_d;

   // Controller registers; reset lands in IDLE on bank 0 with no ack pending
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= RF_IDLE;
         count_q  <= '0;
         target_q <= '0;
         active_q <= '0;
         ack_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         target_q <= target_d;
         active_q <= active_d;
         ack_q    <= ack_d;
      end
   end

   // Next-state logic; index 0 is hardwired zero, so the clear sweep starts at 1
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      target_d = target_q;
      active_d = active_q;
      ack_d    = 1'b0;
      case (state_q)
         RF_IDLE: begin
            if (CTX_SWITCH_REQ) begin
               if (CTX_CLEAR) begin
                  target_d = CTX_ID;
                  count_d  = AW'(1);
                  state_d  = RF_CLEAR;
               end else begin
                  active_d = CTX_ID;
                  ack_d    = 1'b1;
               end
            end
         end
         RF_CLEAR: begin
            count_d = count_q + AW'(1);
            if (count_q == AW'(NREGS - 1)) begin
               active_d = target_q;
               ack_d    = 1'b1;
               state_d  = RF_IDLE;
            end
         end
         default: state_d = RF_IDLE;
      endcase
   end

   assign CTX_BUSY       = (state_q == RF_CLEAR);
   assign CTX_SWITCH_ACK = ack_q;
   assign CTX_ACTIVE     = active_q;
   assign clear_en       = CTX_BUSY;
   assign clear_bank     = target_q;
   assign clear_index    = count_q;

endmodule

// File: rtl/ctx_reg_file.sv
// rtl/ctx_reg_file.sv - multi-context integer register file; RF_WRITE_BYPASS_EN enables write-to-read bypass
import rf_pkg::*;

module ctx_reg_file #(
   parameter int XLEN  = RF_XLEN,
   parameter int NREGS = RF_NREGS,
   parameter int NCTX  = RF_NCTX
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     WRITE,
   input  logic [$clog2(NREGS)-1:0] INADDRESS,
   input  logic [XLEN-1:0]          IN,
   input  logic [$clog2(NREGS)-1:0] OUT1ADDRESS,
   input  logic [$clog2(NREGS)-1:0] OUT2ADDRESS,
   output logic [XLEN-1:0]          OUT1,
   output logic [XLEN-1:0]          OUT2,
   input  logic                     CTX_SWITCH_REQ,
   input  logic [$clog2(NCTX)-1:0]  CTX_ID,
   input  logic                     CTX_CLEAR,
   output logic                     CTX_SWITCH_ACK,
   output logic                     CTX_BUSY,
   output logic [$clog2(NCTX)-1:0]  CTX_ACTIVE
);

   localparam int AW = $clog2(NREGS);
   localparam int CW = $clog2(NCTX);

   logic [XLEN-1:0] bank [NCTX][NREGS];
   logic            clear_en;
   logic [CW-1:0]   clear_bank;
   logic [AW-1:0]   clear_index;
   logic            wr_ok;

   rf_ctx_ctrl #(
      .NREGS (NREGS),
      .NCTX  (NCTX)
   ) u_ctrl (
      .CLK            (CLK),
      .RESET          (RESET),
      .CTX_SWITCH_REQ (CTX_SWITCH_REQ),
      .CTX_ID         (CTX_ID),
      .CTX_CLEAR      (CTX_CLEAR),
      .CTX_SWITCH_ACK (CTX_SWITCH_ACK),
      .CTX_BUSY       (CTX_BUSY),
      .CTX_ACTIVE     (CTX_ACTIVE),
      .clear_en       (clear_en),
      .clear_bank     (clear_bank),
      .clear_index    (clear_index)
   );

   // Writes are dropped while a clear runs (core stalls writeback on BUSY)
   assign wr_ok = WRITE && !CTX_BUSY && (INADDRESS != '0);

   // Storage: clear strobe and writes are exclusive since clear_en equals BUSY
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int c = 0; c < NCTX; c++) begin
            for (int r = 0; r < NREGS; r++) begin
               bank[c][r] <= '0;
            end
         end
      end else if (clear_en) begin
         bank[clear_bank][clear_index] <= '0;
      end else if (wr_ok) begin
         bank[CTX_ACTIVE][INADDRESS] <= IN;
      end
   end

   // Combinational read ports from the active bank; x0 is forced to zero
   always_comb begin
      OUT1 = (OUT1ADDRESS == '0) ? '0 : bank[CTX_ACTIVE][OUT1ADDRESS];
      OUT2 = (OUT2ADDRESS == '0) ? '0 : bank[CTX_ACTIVE][OUT2ADDRESS];
`ifdef RF_WRITE_BYPASS_EN
      if (wr_ok && (INADDRESS == OUT1ADDRESS)) OUT1 = IN;
      if (wr_ok && (INADDRESS == OUT2ADDRESS)) OUT2 = IN;
`endif
   end

endmodule

// File: tb/tb_ctx_reg_file.sv
// tb/tb_ctx_reg_file.sv - self-checking bench for ctx_reg_file with behavioural model
module tb_ctx_reg_file;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NCTX  = 4;

   logic             CLK = 1'b0;
   logic             RESET;
   logic             WRITE;
   logic [4:0]       INADDRESS;
   logic [XLEN-1:0]  IN;
   logic [4:0]       OUT1ADDRESS;
   logic [4:0]       OUT2ADDRESS;
   logic [XLEN-1:0]  OUT1;
   logic [XLEN-1:0]  OUT2;
   logic             CTX_SWITCH_REQ;
   logic [1:0]       CTX_ID;
   logic             CTX_CLEAR;
   logic             CTX_SWITCH_ACK;
   logic             CTX_BUSY;
   logic [1:0]       CTX_ACTIVE;

   int n_checks = 0;
   int n_errors = 0;

   ctx_reg_file #(.XLEN(XLEN), .NREGS(NREGS), .NCTX(NCTX)) dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .WRITE          (WRITE),
      .INADDRESS      (INADDRESS),
      .IN             (IN),
      .OUT1ADDRESS    (OUT1ADDRESS),
      .OUT2ADDRESS    (OUT2ADDRESS),
      .OUT1           (OUT1),
      .OUT2           (OUT2),
      .CTX_SWITCH_REQ (CTX_SWITCH_REQ),
      .CTX_ID         (CTX_ID),
      .CTX_CLEAR      (CTX_CLEAR),
      .CTX_SWITCH_ACK (CTX_SWITCH_ACK),
      .CTX_BUSY       (CTX_BUSY),
      .CTX_ACTIVE     (CTX_ACTIVE)
   );

   always #5 CLK = ~CLK;

   // Reference model: banks as a plain array plus switch bookkeeping
   logic [XLEN-1:0] m_reg [NCTX][NREGS];
   logic [1:0]      m_active;
   logic [1:0]      m_tgt;
   logic            m_ack;
   logic            m_clearing;
   logic [4:0]      m_pos;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [XLEN-1:0] exp_rd(input logic [4:0] a);
      if (a == 5'd0) return '0;
`ifdef RF_WRITE_BYPASS_EN
      if (WRITE && !m_clearing && INADDRESS != 5'd0 && INADDRESS == a) return IN;
`endif
      return m_reg[m_active][a];
   endfunction

   // Model update on each edge, zeroed by the asynchronous reset
   always @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int c = 0; c < NCTX; c++)
            for (int r = 0; r < NREGS; r++)
               m_reg[c][r] <= '0;
         m_active   <= '0;
         m_tgt      <= '0;
         m_ack      <= 1'b0;
         m_clearing <= 1'b0;
         m_pos      <= '0;
      end else begin
         m_ack <= 1'b0;
         if (WRITE && !m_clearing && INADDRESS != 5'd0)
            m_reg[m_active][INADDRESS] <= IN;
         if (m_clearing) begin
            m_reg[m_tgt][m_pos] <= '0;
            if (m_pos == 5'(NREGS - 1)) begin
               m_clearing <= 1'b0;
               m_active   <= m_tgt;
               m_ack      <= 1'b1;
            end else begin
               m_pos <= m_pos + 5'd1;
            end
         end else if (CTX_SWITCH_REQ) begin
            if (CTX_CLEAR) begin
               m_clearing <= 1'b1;
               m_tgt      <= CTX_ID;
               m_pos      <= 5'd1;
            end else begin
               m_active <= CTX_ID;
               m_ack    <= 1'b1;
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model
   always @(negedge CLK) begin
      check("OUT1", OUT1, exp_rd(OUT1ADDRESS));
      check("OUT2", OUT2, exp_rd(OUT2ADDRESS));
      check("ACK", 32'(CTX_SWITCH_ACK), 32'(m_ack));
      check("BUSY", 32'(CTX_BUSY), 32'(m_clearing));
      check("ACTIVE", 32'(CTX_ACTIVE), 32'(m_active));
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      WRITE = 1'b1; INADDRESS = a; IN = d;
      cyc();
      WRITE = 1'b0;
   endtask

   task automatic sw(input logic [1:0] id, input logic clr);
      CTX_SWITCH_REQ = 1'b1; CTX_ID = id; CTX_CLEAR = clr;
      cyc();
      CTX_SWITCH_REQ = 1'b0; CTX_CLEAR = 1'b0;
   endtask

   task automatic rd_check(input string name, input logic [4:0] a, input logic [31:0] exp);
      OUT1ADDRESS = a;
      @(negedge CLK);
      check(name, OUT1, exp);
      cyc();
   endtask

   int busy_cnt, ack_cnt, ack_at;

   initial begin
      RESET = 1'b1; WRITE = 1'b0; INADDRESS = '0; IN = '0;
      OUT1ADDRESS = '0; OUT2ADDRESS = '0;
      CTX_SWITCH_REQ = 1'b0; CTX_ID = '0; CTX_CLEAR = 1'b0;
      cyc(); cyc();
      @(negedge CLK);
      check("rst_out1", OUT1, 32'h0);
      check("rst_active", 32'(CTX_ACTIVE), 32'h0);
      check("rst_busy", 32'(CTX_BUSY), 32'h0);
      check("rst_ack", 32'(CTX_SWITCH_ACK), 32'h0);
      cyc();
      RESET = 1'b0;

      // Basic write/read and x0 hardwired zero
      wr(5'd5, 32'hDEADBEEF);
      rd_check("x5_deadbeef", 5'd5, 32'hDEADBEEF);
      wr(5'd0, 32'h1234);
      rd_check("x0_zero", 5'd0, 32'h0);

      // Plain switch and back
      wr(5'd5, 32'h11);
      sw(2'd2, 1'b0);
      OUT1ADDRESS = 5'd5;
      @(negedge CLK);
      check("sw2_ack", 32'(CTX_SWITCH_ACK), 32'h1);
      check("sw2_active", 32'(CTX_ACTIVE), 32'h2);
      check("sw2_x5", OUT1, 32'h0);
      cyc();
      @(negedge CLK);
      check("sw2_ack_drop", 32'(CTX_SWITCH_ACK), 32'h0);
      cyc();
      wr(5'd5, 32'h22);
      sw(2'd0, 1'b0);
      rd_check("back0_x5", 5'd5, 32'h11);

      // Fill ctx 1, then clear-switch into it with stray REQ and writes while busy
      sw(2'd1, 1'b0);
      for (int i = 1; i < NREGS; i++) wr(5'(i), 32'(i));
      rd_check("ctx1_x9", 5'd9, 32'd9);
      sw(2'd0, 1'b0);
      CTX_SWITCH_REQ = 1'b1; CTX_ID = 2'd1; CTX_CLEAR = 1'b1;
      cyc();
      busy_cnt = 0; ack_cnt = 0; ack_at = 0;
      for (int k = 1; k <= 40; k++) begin
         CTX_SWITCH_REQ = (k <= 5);
         CTX_ID = 2'd3; CTX_CLEAR = 1'b0;
         WRITE = (k <= 31); INADDRESS = 5'(k); IN = 32'hFFFF_0000;
         @(negedge CLK);
         if (CTX_BUSY) busy_cnt++;
         if (CTX_SWITCH_ACK) begin ack_cnt++; ack_at = k; end
         cyc();
      end
      CTX_SWITCH_REQ = 1'b0; WRITE = 1'b0;
      check("clr_busy_cycles", 32'(busy_cnt), 32'd31);
      check("clr_ack_count", 32'(ack_cnt), 32'd1);
      check("clr_ack_cycle", 32'(ack_at), 32'd32);
      check("clr_active", 32'(CTX_ACTIVE), 32'd1);
      for (int i = 0; i < NREGS; i++) rd_check("clr_ctx1_zero", 5'(i), 32'h0);
      sw(2'd0, 1'b0);
      rd_check("clr_ctx0_x5", 5'd5, 32'h11);

      // Reset in cycle 10 of a clear
      sw(2'd2, 1'b1);
      for (int k = 0; k < 9; k++) cyc();
      RESET = 1'b1;
      @(negedge CLK);
      check("mid_rst_busy", 32'(CTX_BUSY), 32'h0);
      check("mid_rst_active", 32'(CTX_ACTIVE), 32'h0);
      cyc();
      RESET = 1'b0;
      ack_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge CLK);
         if (CTX_SWITCH_ACK) ack_cnt++;
         cyc();
      end
      check("mid_rst_no_ack", 32'(ack_cnt), 32'h0);
      for (int c = 0; c < NCTX; c++) begin
         sw(2'(c), 1'b0);
         for (int i = 1; i < NREGS; i++) rd_check("mid_rst_zero", 5'(i), 32'h0);
      end
      sw(2'd0, 1'b0);

      // Write-to-read bypass on port 2
      wr(5'd7, 32'h5A);
      WRITE = 1'b1; INADDRESS = 5'd7; IN = 32'hA5; OUT2ADDRESS = 5'd7;
      @(negedge CLK);
`ifdef RF_WRITE_BYPASS_EN
      check("bypass_same", OUT2, 32'hA5);
`else
      check("nobypass_same", OUT2, 32'h5A);
`endif
      cyc();
      WRITE = 1'b0;
      @(negedge CLK);
      check("bypass_next", OUT2, 32'hA5);
      cyc();

      // Randomized traffic, checked every cycle against the model
      for (int k = 0; k < 3000; k++) begin
         RESET          = ($urandom_range(0, 399) == 0);
         WRITE          = ($urandom_range(0, 2) != 0) && !RESET;
         INADDRESS      = 5'($urandom_range(0, NREGS - 1));
         IN             = $urandom;
         OUT1ADDRESS    = ($urandom_range(0, 3) == 0) ? INADDRESS : 5'($urandom_range(0, NREGS - 1));
         OUT2ADDRESS    = ($urandom_range(0, 3) == 0) ? INADDRESS : 5'($urandom_range(0, NREGS - 1));
         CTX_SWITCH_REQ = ($urandom_range(0, 11) == 0);
         CTX_ID         = 2'($urandom_range(0, NCTX - 1));
         CTX_CLEAR      = ($urandom_range(0, 2) == 0);
         cyc();
      end
      RESET = 1'b0; WRITE = 1'b0; CTX_SWITCH_REQ = 1'b0;
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
